// File: rtl/ifetch_unit_32.sv
// ifetch_unit_32: instruction fetch unit for the single-cycle MIPS datapath.
// It reads the PC register output and issues a req/ack read to instruction
// memory. The returned word is held for decode under a valid/ready handshake.
// pc_advance pulses once per accepted fetch so the PC register can step.
// A misaligned PC or a memory timeout drops the unit into a sticky error
// state that only reset clears.
// Optional build macro IFETCH_PERF_CNT_EN adds the fetch_cnt and stall_cnt
// performance counters.
module ifetch_unit_32 #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                TIMEOUT   = 16,
    parameter logic [DATA_W-1:0] NOP_INSTR = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_en,
    input  logic              flush,
    input  logic [ADDR_W-1:0] pc_addr,
    output logic              pc_advance,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic              fetch_err
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [31:0]       fetch_cnt,
    output logic [31:0]       stall_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        ERR  = 2'd3
    } state_e;

    // The counter must be able to hold TIMEOUT itself.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_e              state_q, state_d;
    logic                imem_req_q, imem_req_d;
    logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
    logic                pc_advance_q, pc_advance_d;
    logic [DATA_W-1:0]   instr_q, instr_d;
    logic [ADDR_W-1:0]   instr_pc_q, instr_pc_d;
    logic                instr_valid_q, instr_valid_d;
    logic                fetch_err_q, fetch_err_d;
    logic [CNT_W-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic                discard_q, discard_d;

    logic                pc_aligned;
    logic [CNT_W-1:0]    tmo_next;

    assign pc_aligned = (pc_addr[1:0] == 2'b00);
    assign tmo_next   = tmo_cnt_q + CNT_W'(1);

    // Next-state and next-output computation for the fetch sequencer.
    always_comb begin
        // NOTE: every _d gets a default here so no path can infer a latch.
        state_d       = state_q;
        imem_req_d    = imem_req_q;
        imem_addr_d   = imem_addr_q;
        pc_advance_d  = 1'b0;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        fetch_err_d   = fetch_err_q;
        tmo_cnt_d     = tmo_cnt_q;
        discard_d     = discard_q;

        unique case (state_q)
            IDLE: begin
                if (fetch_en && !flush) begin
                    if (pc_aligned) begin
                        imem_addr_d = pc_addr;
                        imem_req_d  = 1'b1;
                        tmo_cnt_d   = '0;
                        discard_d   = 1'b0;
                        state_d     = REQ;
                    end else begin
                        fetch_err_d = 1'b1;
                        state_d     = ERR;
                    end
                end
            end

            REQ: begin
                if (imem_ack) begin
                    imem_req_d = 1'b0;
                    // A flush arriving together with the ack also kills the data.
                    if (discard_q || flush) begin
                        discard_d = 1'b0;
                        state_d   = IDLE;
                    end else begin
                        instr_d       = imem_rdata;
                        instr_pc_d    = imem_addr_q;
                        instr_valid_d = 1'b1;
                        pc_advance_d  = 1'b1;
                        state_d       = HOLD;
                    end
                end else begin
                    tmo_cnt_d = tmo_next;
                    // The bus request cannot be withdrawn, so remember to drop its data.
                    if (flush) begin
                        discard_d = 1'b1;
                    end
                    if ((TIMEOUT != 0) && (tmo_next == CNT_W'(TIMEOUT))) begin
                        imem_req_d  = 1'b0;
                        fetch_err_d = 1'b1;
                        state_d     = ERR;
                    end
                end
            end

            HOLD: begin
                if (flush) begin
                    instr_valid_d = 1'b0;
                    instr_d       = NOP_INSTR;
                    state_d       = IDLE;
                end else if (instr_ready) begin
                    instr_valid_d = 1'b0;
                    if (fetch_en && pc_aligned) begin
                        imem_addr_d = pc_addr;
                        imem_req_d  = 1'b1;
                        tmo_cnt_d   = '0;
                        discard_d   = 1'b0;
                        state_d     = REQ;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            ERR: begin
                imem_req_d    = 1'b0;
                instr_valid_d = 1'b0;
                fetch_err_d   = 1'b1;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any in-flight request at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            imem_req_q    <= 1'b0;
            imem_addr_q   <= '0;
            pc_advance_q  <= 1'b0;
            instr_q       <= NOP_INSTR;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            fetch_err_q   <= 1'b0;
            tmo_cnt_q     <= '0;
            discard_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value of the others.
            state_q       <= state_d;
            imem_req_q    <= imem_req_d;
            imem_addr_q   <= imem_addr_d;
            pc_advance_q  <= pc_advance_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            fetch_err_q   <= fetch_err_d;
            tmo_cnt_q     <= tmo_cnt_d;
            discard_q     <= discard_d;
        end
    end

    assign pc_advance  = pc_advance_q;
    assign imem_req    = imem_req_q;
    assign imem_addr   = imem_addr_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;
    assign fetch_err   = fetch_err_q;

`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic        stall_now;

    assign stall_now = ((state_q == REQ) && !imem_ack) ||
                       ((state_q == HOLD) && !instr_ready);

    // Counter increments; both wrap naturally at 2^32.
    always_comb begin
        fetch_cnt_d = fetch_cnt_q + (pc_advance_q ? 32'd1 : 32'd0);
        stall_cnt_d = stall_cnt_q + (stall_now ? 32'd1 : 32'd0);
    end

    // Performance counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ifetch_unit_32.sv
// Self-checking bench for ifetch_unit_32: a transaction-level model of the
// fetch unit is compared against the DUT every cycle, and directed scenarios
// add hand-computed literal expectations.
module tb_ifetch_unit_32;

    localparam int          TIMEOUT = 16;
    localparam logic [31:0] NOP     = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic        fetch_en;
    logic        flush;
    logic [31:0] pc_addr;
    logic        pc_advance;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        fetch_err;
`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;
`endif

    ifetch_unit_32 #(
        .ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT), .NOP_INSTR(NOP)
    ) dut (
        .clk(clk), .reset(reset), .fetch_en(fetch_en), .flush(flush),
        .pc_addr(pc_addr), .pc_advance(pc_advance), .imem_req(imem_req),
        .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .fetch_err(fetch_err)
`ifdef IFETCH_PERF_CNT_EN
        , .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- memory responder ----------------
    logic        mem_en = 1'b0;
    int          mem_lat = 0;
    logic [31:0] mem_data = 32'h0;
    logic        mem_ack_r = 1'b0;
    logic        ack_force = 1'b0;
    int          mem_cnt = 0;

    assign imem_ack   = mem_ack_r | ack_force;
    assign imem_rdata = mem_data;

    always @(negedge clk) begin
        if (imem_req && mem_en) begin
            if (mem_cnt >= mem_lat) begin
                mem_ack_r = 1'b1;
            end else begin
                mem_ack_r = 1'b0;
                mem_cnt++;
            end
        end else begin
            mem_ack_r = 1'b0;
            mem_cnt   = 0;
        end
    end

    // ---------------- transaction-level model ----------------
    // A fetch is either pending on the bus, held for decode, or neither;
    // errors are a sticky dead flag.
    logic        m_err, m_pend, m_disc, m_held, m_adv;
    logic [31:0] m_paddr, m_instr, m_ipc;
    int          m_wait;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_err = 0; m_pend = 0; m_disc = 0; m_held = 0; m_adv = 0;
            m_paddr = 0; m_instr = NOP; m_ipc = 0; m_wait = 0;
        end else begin
            m_adv = 0;
            if (m_err) begin
                // dead until reset
            end else if (m_pend) begin
                if (imem_ack) begin
                    m_pend = 0;
                    if (m_disc || flush) m_disc = 0;
                    else begin
                        m_held = 1; m_instr = imem_rdata; m_ipc = m_paddr; m_adv = 1;
                    end
                end else begin
                    if (flush) m_disc = 1;
                    m_wait++;
                    if (TIMEOUT != 0 && m_wait == TIMEOUT) begin
                        m_pend = 0; m_err = 1;
                    end
                end
            end else if (m_held) begin
                if (flush) begin
                    m_held = 0; m_instr = NOP;
                end else if (instr_ready) begin
                    m_held = 0;
                    if (fetch_en && pc_addr[1:0] == 2'b00) begin
                        m_pend = 1; m_paddr = pc_addr; m_wait = 0; m_disc = 0;
                    end
                end
            end else if (fetch_en && !flush) begin
                if (pc_addr[1:0] == 2'b00) begin
                    m_pend = 1; m_paddr = pc_addr; m_wait = 0; m_disc = 0;
                end else begin
                    m_err = 1;
                end
            end
        end
    end

    // ---------------- per-cycle compare + event counters ----------------
    int adv_cnt = 0;
    int req_cnt = 0;

    always @(negedge clk) begin
        if (pc_advance) adv_cnt++;
        if (imem_req)   req_cnt++;
        if (reset) begin
            check("cyc imem_req",    {31'b0, imem_req},    {31'b0, m_pend});
            check("cyc imem_addr",   imem_addr,            m_paddr);
            check("cyc pc_advance",  {31'b0, pc_advance},  {31'b0, m_adv});
            check("cyc instr_valid", {31'b0, instr_valid}, {31'b0, m_held});
            check("cyc instr",       instr,                m_instr);
            check("cyc instr_pc",    instr_pc,             m_ipc);
            check("cyc fetch_err",   {31'b0, fetch_err},   {31'b0, m_err});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic logic sig(input int which);
        case (which)
            0:       return instr_valid;
            1:       return imem_req;
            2:       return pc_advance;
            default: return fetch_err;
        endcase
    endfunction

    task automatic wait_sig(input int which, input int max_cycles, input string name);
        for (int i = 0; i < max_cycles; i++) begin
            if (sig(which)) return;
            step();
        end
        check({name, " timeout"}, 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        reset = 1'b1;
        step();
    endtask

    int a0, r0, n;

    initial begin
        reset = 1'b0; fetch_en = 0; flush = 0; pc_addr = 0; instr_ready = 0;
        #10 reset = 1'b1;
        step();

        // Reset state
        check("rst instr",       instr, NOP);
        check("rst instr_pc",    instr_pc, 32'h0);
        check("rst imem_addr",   imem_addr, 32'h0);
        check("rst flags", {28'b0, imem_req, instr_valid, pc_advance, fetch_err}, 32'h0);

        // Reset then fetch: ack one cycle after req
        a0 = adv_cnt;
        mem_en = 1; mem_lat = 1; mem_data = 32'h2108_0001;
        pc_addr = 32'h0000_0004; fetch_en = 1; instr_ready = 1;
        wait_sig(1, 10, "first req");
        check("first imem_addr", imem_addr, 32'h0000_0004);
        wait_sig(0, 10, "first valid");
        fetch_en = 0;
        check("first instr",    instr, 32'h2108_0001);
        check("first instr_pc", instr_pc, 32'h0000_0004);
        step(); step();
        check("first adv pulses", adv_cnt - a0, 32'd1);
        check("first idle valid", {31'b0, instr_valid}, 32'd0);

        // Backpressure: ready low 5 cycles after valid, then back-to-back
        mem_lat = 0; mem_data = 32'h8C22_0010; instr_ready = 0;
        pc_addr = 32'h0000_0040; fetch_en = 1;
        wait_sig(0, 10, "bp valid");
        pc_addr = 32'h0000_0044; mem_data = 32'h0000_0000;
        r0 = req_cnt;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp instr",    instr, 32'h8C22_0010);
            check("bp instr_pc", instr_pc, 32'h0000_0040);
            check("bp valid",    {31'b0, instr_valid}, 32'd1);
        end
        check("bp no req", req_cnt - r0, 32'd0);
        mem_data = 32'h1234_5678;
        instr_ready = 1;
        step();
        check("b2b req",  {31'b0, imem_req}, 32'd1);
        check("b2b addr", imem_addr, 32'h0000_0044);
        fetch_en = 0;
        step();
        check("b2b instr", instr, 32'h1234_5678);
        step(); step();

        // Throughput: zero-wait memory, ready high -> one instruction per 2 cycles
        mem_lat = 0; mem_data = 32'h0042_1820; pc_addr = 32'h0000_0080;
        fetch_en = 1; instr_ready = 1;
        wait_sig(2, 10, "tput adv");
        a0 = adv_cnt;
        step();
        check("tput +1", adv_cnt - a0, 32'd0);
        step();
        check("tput +2", adv_cnt - a0, 32'd1);
        for (int i = 0; i < 10; i++) step();
        check("tput +12", adv_cnt - a0, 32'd6);
        fetch_en = 0;
        step(); step(); step();

        // Flush in flight: flush during REQ, then ack with all-ones data
        a0 = adv_cnt;
        mem_lat = 3; mem_data = 32'hFFFF_FFFF; pc_addr = 32'h0000_0008; fetch_en = 1;
        wait_sig(1, 10, "fl req");
        fetch_en = 0; flush = 1;
        step();
        flush = 0;
        check("fl req held", {31'b0, imem_req}, 32'd1);
        for (int i = 0; i < 6; i++) step();
        check("fl no valid", {31'b0, instr_valid}, 32'd0);
        check("fl no adv",   adv_cnt - a0, 32'd0);
        check("fl idle req", {31'b0, imem_req}, 32'd0);

        // Flush arriving in the same cycle as the ack
        a0 = adv_cnt;
        mem_lat = 1; mem_data = 32'hCAFE_0001; pc_addr = 32'h0000_0020; fetch_en = 1;
        step();
        step();
        check("fa ack", {31'b0, imem_ack}, 32'd1);
        fetch_en = 0; flush = 1;
        step();
        flush = 0;
        step(); step();
        check("fa no valid", {31'b0, instr_valid}, 32'd0);
        check("fa no adv",   adv_cnt - a0, 32'd0);

        // Flush while holding: flush wins over ready, instr returns to NOP
        mem_lat = 0; mem_data = 32'hDEAD_BEEF; pc_addr = 32'h0000_0100;
        fetch_en = 1; instr_ready = 0;
        wait_sig(0, 10, "fh valid");
        check("fh instr", instr, 32'hDEAD_BEEF);
        fetch_en = 0; flush = 1; instr_ready = 1;
        step();
        flush = 0;
        check("fh valid", {31'b0, instr_valid}, 32'd0);
        check("fh nop",   instr, NOP);
        step();

        // Misaligned PC: sticky error, no request
        r0 = req_cnt;
        pc_addr = 32'h0000_0001; fetch_en = 1;
        step(); step();
        check("mis err", {31'b0, fetch_err}, 32'd1);
        pc_addr = 32'h0000_0010;
        for (int i = 0; i < 5; i++) step();
        check("mis sticky", {31'b0, fetch_err}, 32'd1);
        check("mis no req", req_cnt - r0, 32'd0);
        fetch_en = 0;
        do_reset();
        check("mis cleared", {31'b0, fetch_err}, 32'd0);

        // Timeout: memory never acks
        mem_en = 0; pc_addr = 32'h0000_0010; fetch_en = 1;
        wait_sig(1, 10, "tmo req");
        r0 = req_cnt - 1;
        fetch_en = 0;
        wait_sig(3, 40, "tmo err");
        check("tmo req cycles", req_cnt - r0, 32'd16);
        check("tmo req drop",   {31'b0, imem_req}, 32'd0);
        step(); step();
        check("tmo sticky", {31'b0, fetch_err}, 32'd1);
        do_reset();

        // Async reset mid-REQ; a late ack is then ignored
        a0 = adv_cnt;
        mem_en = 0; pc_addr = 32'h0000_0030; fetch_en = 1;
        wait_sig(1, 10, "ar req");
        fetch_en = 0;
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("ar req",   {31'b0, imem_req}, 32'd0);
        check("ar valid", {31'b0, instr_valid}, 32'd0);
        check("ar addr",  imem_addr, 32'h0);
        step();
        ack_force = 1; mem_data = 32'h0BAD_0BAD;
        reset = 1'b1;
        step(); step();
        ack_force = 0;
        check("ar late valid", {31'b0, instr_valid}, 32'd0);
        check("ar late adv",   adv_cnt - a0, 32'd0);
        check("ar late instr", instr, NOP);
        n = 0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifetch_unit_32.md
Name: ifetch_unit_32

Overview:
- Instruction fetch unit for the single-cycle MIPS datapath.
- Consumes the address held in the PC register, issues a read to instruction memory over a req/ack handshake, and holds the returned word for decode under a valid/ready handshake.
- Pulses pc_advance so the PC register loads its next address.
- Sits between the PC register output and the decode stage; reader side of the PC-register/memory address interface.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, instruction width.
- TIMEOUT, 16, max cycles waiting for imem_ack before error; 0 disables timeout.
- NOP_INSTR, 32'h0000_0000, value driven on instr at reset and after flush.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- fetch_en  input  1  permit new fetches.
- flush  input  1  discard held or in-flight instruction (branch/jump taken).
- pc_addr  input  ADDR_W  current PC (PC register new_addr).
- pc_advance  output  1  one-cycle pulse: PC register may load next address.
- imem_req  output  1  memory read request.
- imem_addr  output  ADDR_W  read address, stable while imem_req=1.
- imem_ack  input  1  memory read complete, rdata valid this cycle.
- imem_rdata  input  DATA_W  read data.
- instr  output  DATA_W  fetched instruction.
- instr_pc  output  ADDR_W  address instr was fetched from.
- instr_valid  output  1  instr available to decode.
- instr_ready  input  1  decode accepts instr.
- fetch_err  output  1  sticky error flag (misaligned or timeout).

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, imem_req=0, imem_addr=0, pc_advance=0.
  - instr=NOP_INSTR, instr_pc=0, instr_valid=0, fetch_err=0.
  - Timeout counter and discard flag cleared.
  - Mid-transaction reset aborts the request immediately; a late imem_ack after reset is ignored.
- States: IDLE, REQ, HOLD, ERR.
- IDLE:
  - fetch_en=1 and flush=0, with pc_addr[1:0]==0: latch pc_addr into imem_addr, imem_req=1 next cycle, go to REQ.
  - Same conditions with pc_addr[1:0]!=0: go to ERR with fetch_err=1; no request is issued.
- REQ:
  - imem_req and imem_addr held stable until imem_ack.
  - On imem_ack with discard=0: next cycle instr=imem_rdata, instr_pc=imem_addr, instr_valid=1, pc_advance=1 for exactly one cycle, imem_req=0, go to HOLD.
  - On imem_ack with discard=1: drop the data, no pc_advance, clear discard, imem_req=0, go to IDLE.
  - flush=1 while in REQ: set discard; the request is not withdrawn.
  - Timeout counter increments each REQ cycle without ack. If TIMEOUT≠0 and the count reaches TIMEOUT, go to ERR and drop imem_req.
- HOLD:
  - instr_valid stays 1 and instr is stable until instr_valid&instr_ready.
  - On that handshake, fetch_en=1 with an aligned pc_addr: back-to-back, new imem_req next cycle, go to REQ.
  - On that handshake otherwise: go to IDLE, instr_valid=0.
  - flush=1 in HOLD: instr_valid=0, instr=NOP_INSTR next cycle, go to IDLE; flush wins over a same-cycle instr_ready.
- ERR: fetch_err=1, imem_req=0, instr_valid=0; only reset exits.
- Throughput: zero-wait memory (ack in the first REQ cycle) with ready tied high gives one instruction per 2 cycles.
- Simultaneous flush and imem_ack in REQ: the data is discarded.

Optional Feature:
- Macro: IFETCH_PERF_CNT_EN.
- Defined:
  - Adds output fetch_cnt[31:0], incremented on each pc_advance.
  - Adds output stall_cnt[31:0], incremented each cycle in REQ without ack, or in HOLD with instr_ready=0.
  - Both counters reset to 0 and wrap at 2^32.
- Undefined: the ports and logic are absent; the rest of the behaviour is identical.

Test Plan:
- Reset then fetch:
  - Stimulus: reset low 10ns then high; pc_addr=32'h0000_0004, fetch_en=1, memory acks 1 cycle after req with rdata=32'h2108_0001, instr_ready=1.
  - Response: imem_addr=32'h0000_0004; instr=32'h2108_0001; instr_pc=32'h0000_0004; single pc_advance pulse.
- Backpressure:
  - Stimulus: instr_ready=0 for 5 cycles after valid.
  - Response: instr, instr_valid, instr_pc unchanged; no new imem_req until the ready handshake.
- Flush in flight:
  - Stimulus: flush pulsed while in REQ for addr 32'h0000_0008, then ack with rdata=32'hFFFF_FFFF.
  - Response: instr_valid stays 0; no pc_advance; state IDLE.
- Misaligned:
  - Stimulus: pc_addr=32'h0000_0001, fetch_en=1.
  - Response: imem_req never asserted; fetch_err=1 sticky until reset low.
- Timeout:
  - Stimulus: TIMEOUT=16, imem_ack held 0.
  - Response: fetch_err=1 after 16 REQ cycles; imem_req drops.
- Async reset mid-REQ:
  - Stimulus: reset=0 between clock edges.
  - Response: imem_req=0 and instr_valid=0 immediately; a following ack is ignored.
